// File: rtl/seq_mul_add.sv
// Sequential radix-2 shift-add multiplier-accumulator: d = q*m + r.
// One multiplier bit is consumed per clock, LSB first, under a start/busy/done handshake.
module seq_mul_add #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   q,
    input  logic [N-1:0]   m,
    input  logic [N-1:0]   r,
    output logic [2*N-1:0] d,
    output logic           busy,
    output logic           done,
    output logic           rem_err
);
    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state_q, state_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic [2*N-1:0] mcand_q, mcand_d;
    logic [2*N-1:0] d_q, d_d;
    logic [2*N-1:0] acc_sum;
    logic [N-1:0]   qsh_q, qsh_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           err_q, err_d;
    logic           rem_err_q, rem_err_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    // Max q*m+r is 2^2N - 2^N, so the 2N-bit sum never carries out.
    assign acc_sum = acc_q + (qsh_q[0] ? mcand_q : {(2*N){1'b0}});

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        qsh_d     = qsh_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        d_d       = d_q;
        rem_err_d = rem_err_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    acc_d   = {{N{1'b0}}, r};
                    mcand_d = {{N{1'b0}}, m};
                    qsh_d   = q;
                    cnt_d   = '0;
                    err_d   = (r >= m);
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                acc_d   = acc_sum;
                mcand_d = mcand_q << 1;
                qsh_d   = qsh_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d   = DONE;
                    d_d       = acc_sum;
                    rem_err_d = err_q;
                    done_d    = 1'b1;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            qsh_q     <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            d_q       <= '0;
            rem_err_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            qsh_q     <= qsh_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            d_q       <= d_d;
            rem_err_q <= rem_err_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign d       = d_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign rem_err = rem_err_q;
endmodule
